// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: word geometry, Rcon table and the
// controller state encoding. The ZERO state only exists when the design is
// built with KEY_SCHED_ZEROIZE_EN.
package aes_pkg;

  localparam int WORD_SIZE = 32;
  localparam int Nb        = 4;

`ifdef KEY_SCHED_ZEROIZE_EN
  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, DONE, ZERO} ks_state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, DONE} ks_state_e;
`endif

  // Round constant leading byte: x^(j-1) in GF(2^8), valid for j = 1..10
  function automatic logic [7:0] rcon(input logic [3:0] j);
    case (j)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: the AES S-box applied to each byte of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_SIZE-1:0] word_i,
  output logic [WORD_SIZE-1:0] word_o
);

  // Forward S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos  = 11'd2040 - {x, 3'b000};
    sbox = SBOX[pos +: 8];
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_o[8*gi +: 8] = sbox(word_i[8*gi +: 8]);
  end

endmodule

// File: rtl/key_sched_ctrl.sv
// AES key-schedule controller: loads a 128/192/256-bit key, expands one
// word per cycle into a word array and serves 128-bit round keys on request.
// Build option KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes the
// stored schedule one word per cycle.
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  input  logic                    start,
  input  logic [NK*WORD_SIZE-1:0] key_in,
  output logic                    busy,
  output logic                    keys_ready,
  input  logic                    rk_req,
  input  logic [3:0]              rk_idx,
  output logic                    rk_valid,
  output logic [Nb*WORD_SIZE-1:0] rk_out
);

  localparam int WORDS = Nb * (NR + 1);

  ks_state_e               state_q;
  logic [NK*WORD_SIZE-1:0] key_q;
  logic [5:0]              i_q;      // index of the word being produced
  logic [2:0]              m_q;      // i mod NK
  logic [3:0]              j_q;      // i / NK, selects Rcon
  logic                    busy_q;
  logic                    keys_ready_q;
  logic                    rk_valid_q;
  logic [Nb*WORD_SIZE-1:0] rk_out_q;
  logic [WORD_SIZE-1:0]    w_q [WORDS];

  logic [WORD_SIZE-1:0]    w_prev, w_back, sub_in, sub_out, temp, new_word_d;
  logic [WORD_SIZE-1:0]    key_word [8];
  logic [5:0]              rk_base;
  logic [WORD_SIZE-1:0]    rk_word [Nb];
  logic [Nb*WORD_SIZE-1:0] rk_data;

  // Key words in w[] order; w[0] comes from the MSBs of the key
  for (genvar gi = 0; gi < 8; gi++) begin : g_key
    if (gi < NK) begin : g_used
      assign key_word[gi] = key_q[(NK-1-gi)*WORD_SIZE +: WORD_SIZE];
    end else begin : g_pad
      assign key_word[gi] = '0;
    end
  end

  // Single S-box shared by the RotWord+Rcon case and the NK=8 mid-key case
  assign w_prev = w_q[i_q - 6'd1];
  assign w_back = w_q[i_q - 6'(NK)];
  assign sub_in = (m_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  // Next schedule word w[i] from w[i-1] and w[i-NK]
  always_comb begin
    temp = w_prev;
    if (m_q == 3'd0) begin
      temp = sub_out ^ {rcon(j_q), 24'h0};
    end else if (NK > 6 && m_q == 3'd4) begin
      temp = sub_out;
    end
    new_word_d = w_back ^ temp;
  end

  // 128-bit read port: words 4r..4r+3 of the stored schedule
  assign rk_base = {rk_idx, 2'b00};
  for (genvar gi = 0; gi < Nb; gi++) begin : g_rk
    assign rk_word[gi] = w_q[rk_base + 6'(gi)];
  end
  assign rk_data = {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};

  // Controller FSM, word storage writes and registered round-key reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      keys_ready_q <= 1'b0;
      rk_valid_q   <= 1'b0;
      rk_out_q     <= '0;
      i_q          <= '0;
      m_q          <= '0;
      j_q          <= '0;
    end else begin
      // Reads see the schedule as it stands before this edge's writes
      rk_valid_q <= 1'b0;
      if (rk_req && keys_ready_q) begin
        rk_valid_q <= 1'b1;
        rk_out_q   <= (rk_idx <= 4'(NR)) ? rk_data : '0;
      end

`ifdef KEY_SCHED_ZEROIZE_EN
      if (zeroize) begin
        state_q      <= ZERO;
        busy_q       <= 1'b1;
        keys_ready_q <= 1'b0;
        i_q          <= '0;
      end else
`endif
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            key_q        <= key_in;
            state_q      <= LOAD;
            busy_q       <= 1'b1;
            keys_ready_q <= 1'b0;
          end
        end
        LOAD: begin
          for (int k = 0; k < NK; k++) begin
            w_q[k[5:0]] <= key_word[k[2:0]];
          end
          i_q     <= 6'(NK);
          m_q     <= '0;
          j_q     <= 4'd1;
          state_q <= EXPAND;
        end
        EXPAND: begin
          w_q[i_q] <= new_word_d;
          if (i_q == 6'(WORDS - 1)) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            keys_ready_q <= 1'b1;
          end else begin
            i_q <= i_q + 6'd1;
            if (m_q == 3'(NK - 1)) begin
              m_q <= '0;
              j_q <= j_q + 4'd1;
            end else begin
              m_q <= m_q + 3'd1;
            end
          end
        end
`ifdef KEY_SCHED_ZEROIZE_EN
        ZERO: begin
          w_q[i_q] <= '0;
          if (i_q == 6'(WORDS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            i_q     <= '0;
          end else begin
            i_q <= i_q + 6'd1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign keys_ready = keys_ready_q;
  assign rk_valid   = rk_valid_q;
  assign rk_out     = rk_out_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: one NK=4 and one NK=8 instance.
// Expected round keys are queued when a read is issued; a monitor per
// instance pops and compares whenever rk_valid is seen.
`timescale 1ns/1ps
module tb_key_sched_ctrl;

  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZR1   = 128'h62636363626363636263636362636363;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] B_R0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_R1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] B_R14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_a, start_a, busy_a, keys_ready_a, rk_req_a, rk_valid_a;
  logic [127:0] key_in_a, rk_out_a;
  logic [3:0]   rk_idx_a;
  logic         rst_n_b, start_b, busy_b, keys_ready_b, rk_req_b, rk_valid_b;
  logic [255:0] key_in_b;
  logic [127:0] rk_out_b;
  logic [3:0]   rk_idx_b;
`ifdef KEY_SCHED_ZEROIZE_EN
  logic         zeroize_tie = 1'b0;
`endif

  key_sched_ctrl #(.NK(4), .NR(10)) dut_a (
    .clk(clk), .rst_n(rst_n_a),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroize_tie),
`endif
    .start(start_a), .key_in(key_in_a), .busy(busy_a), .keys_ready(keys_ready_a),
    .rk_req(rk_req_a), .rk_idx(rk_idx_a), .rk_valid(rk_valid_a), .rk_out(rk_out_a)
  );

  key_sched_ctrl #(.NK(8), .NR(14)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
`ifdef KEY_SCHED_ZEROIZE_EN
    .zeroize(zeroize_tie),
`endif
    .start(start_b), .key_in(key_in_b), .busy(busy_b), .keys_ready(keys_ready_b),
    .rk_req(rk_req_b), .rk_idx(rk_idx_b), .rk_valid(rk_valid_b), .rk_out(rk_out_b)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] q_a[$];
  logic [127:0] q_b[$];
  logic [127:0] exp_a, exp_b;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitors: every rk_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rk_valid_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_valid", {127'd0, rk_valid_a}, 128'd0);
      end else begin
        exp_a = q_a.pop_front();
        $display("read a: rk_out=%h expected=%h", rk_out_a, exp_a);
        chk("a_rk_out", rk_out_a, exp_a);
      end
    end
    if (rk_valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_valid", {127'd0, rk_valid_b}, 128'd0);
      end else begin
        exp_b = q_b.pop_front();
        $display("read b: rk_out=%h expected=%h", rk_out_b, exp_b);
        chk("b_rk_out", rk_out_b, exp_b);
      end
    end
  end

  task automatic rd_a(input logic [3:0] idx, input logic [127:0] exp);
    rk_req_a = 1'b1; rk_idx_a = idx; q_a.push_back(exp);
    @(posedge clk); #1; rk_req_a = 1'b0;
    @(posedge clk); #1;
    chk("a_rk_hold", rk_out_a, exp);
  endtask

  task automatic rd_none_a(input logic [3:0] idx);
    rk_req_a = 1'b1; rk_idx_a = idx;
    @(posedge clk); #1; rk_req_a = 1'b0;
    chk("a_no_valid", {127'd0, rk_valid_a}, 128'd0);
  endtask

  task automatic go_a(input logic [127:0] key);
    key_in_a = key; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
  endtask

  // n0 = edges already elapsed since (and including) the start edge
  task automatic wait_ready_a(input int n0, input int exp, input string name);
    int n = n0;
    while (keys_ready_a !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    $display("latency a (%s): %0d cycles", name, n);
    chk(name, 128'(n), 128'(exp));
  endtask

  task automatic rd_b(input logic [3:0] idx, input logic [127:0] exp);
    rk_req_b = 1'b1; rk_idx_b = idx; q_b.push_back(exp);
    @(posedge clk); #1; rk_req_b = 1'b0;
    @(posedge clk); #1;
    chk("b_rk_hold", rk_out_b, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n_a = 1'b0; start_a = 1'b0; key_in_a = '0; rk_req_a = 1'b0; rk_idx_a = '0;
    rst_n_b = 1'b0; start_b = 1'b0; key_in_b = '0; rk_req_b = 1'b0; rk_idx_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_busy",       {127'd0, busy_a},       128'd0);
    chk("a_rst_keys_ready", {127'd0, keys_ready_a}, 128'd0);
    chk("a_rst_rk_valid",   {127'd0, rk_valid_a},   128'd0);
    chk("a_rst_rk_out",     rk_out_a,               128'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(posedge clk); #1;

    // Read with no schedule stored gets no response
    rd_none_a(4'd0);

    // Expansion of the FIPS-197 key; a second start while busy is ignored
    go_a(K128);
    chk("a_busy_after_start", {127'd0, busy_a}, 128'd1);
    key_in_a = '0; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    rd_none_a(4'd0);
    wait_ready_a(3, 42, "a_latency_1");
    chk("a_busy_done", {127'd0, busy_a}, 128'd0);
    rd_a(4'd0, K128);
    rd_a(4'd1, R1);
    rd_a(4'd2, R2);
    rd_a(4'd10, R10);
    rd_a(4'd11, 128'd0);
    rd_a(4'd15, 128'd0);

    // Read and restart in the same cycle: read comes from the old schedule
    key_in_a = '0; start_a = 1'b1; rk_req_a = 1'b1; rk_idx_a = 4'd1; q_a.push_back(R1);
    @(posedge clk); #1; start_a = 1'b0; rk_req_a = 1'b0;
    chk("a_ready_drop", {127'd0, keys_ready_a}, 128'd0);
    chk("a_busy_restart", {127'd0, busy_a}, 128'd1);
    wait_ready_a(1, 42, "a_latency_2");
    rd_a(4'd1, ZR1);
    rd_a(4'd0, 128'd0);

    // Reset in the middle of expansion, then a fresh start
    go_a(K128);
    repeat (21) @(posedge clk);
    #1; rst_n_a = 1'b0;
    @(posedge clk); #1;
    chk("a_midrst_keys_ready", {127'd0, keys_ready_a}, 128'd0);
    chk("a_midrst_busy",       {127'd0, busy_a},       128'd0);
    chk("a_midrst_rk_out",     rk_out_a,               128'd0);
    rst_n_a = 1'b1;
    @(posedge clk); #1;
    rd_none_a(4'd10);
    go_a(K128);
    wait_ready_a(1, 42, "a_latency_3");
    rd_a(4'd1, R1);
    rd_a(4'd10, R10);

    // 256-bit key on the NK=8 instance
    key_in_b = K256; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    n = 1;
    while (keys_ready_b !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    $display("latency b: %0d cycles", n);
    chk("b_latency", 128'(n), 128'd54);
    rd_b(4'd0, B_R0);
    rd_b(4'd1, B_R1);
    rd_b(4'd14, B_R14);
    rd_b(4'd15, 128'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", 128'(q_a.size()), 128'd0);
    chk("b_queue_drained", 128'(q_b.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
